// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper: walks every input vector through a candidate and a golden
// netlist and scores mismatches. Define SWEEP_HAMMING_EN to build bit-level (Hamming) scoring.
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic [N_IN-1:0]                  vec_out,
    input  logic [N_OUT-1:0]                 dut_out,
    input  logic [N_OUT-1:0]                 gold_out,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [N_IN:0]                    err_cnt,
    output logic [N_IN+$clog2(N_OUT+1)-1:0]  bit_err_cnt,
    output logic                             first_fail_vld,
    output logic [N_IN-1:0]                  first_fail_vec
);

    localparam int BW = N_IN + $clog2(N_OUT + 1);
    localparam logic [7:0] SETTLE_W = 8'(SETTLE);
    localparam logic [N_IN:0] ERR_ONE = (N_IN + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [7:0] wcnt;
    logic       mismatch;

    assign mismatch = (dut_out != gold_out);

`ifdef SWEEP_HAMMING_EN
    logic [N_OUT-1:0] diff;
    logic [BW-1:0]    diff_bits;

    assign diff = dut_out ^ gold_out;

    always_comb begin
        diff_bits = '0;
        for (int i = 0; i < N_OUT; i++)
            diff_bits = diff_bits + BW'(diff[i]);
    end
`else
    assign bit_err_cnt = '0;
`endif

    // Each vector is held for SETTLE wait cycles, then scored on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            vec_out        <= '0;
            wcnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
`ifdef SWEEP_HAMMING_EN
            bit_err_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        vec_out        <= '0;
                        wcnt           <= SETTLE_W;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_vec <= '0;
`ifdef SWEEP_HAMMING_EN
                        bit_err_cnt    <= '0;
`endif
                    end
                end
                RUN: begin
                    if (wcnt != 8'd0) begin
                        wcnt <= wcnt - 8'd1;
                    end else begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + ERR_ONE;
                            if (!first_fail_vld) begin
                                first_fail_vld <= 1'b1;
                                first_fail_vec <= vec_out;
                            end
                        end
`ifdef SWEEP_HAMMING_EN
                        bit_err_cnt <= bit_err_cnt + diff_bits;
`endif
                        // The last vector ends the sweep; vec_out is held, never wrapped.
                        if (&vec_out) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mismatch && (err_cnt == '0);
                        end else begin
                            vec_out <= vec_out + 1'b1;
                            wcnt    <= SETTLE_W;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: gold is a^b, the candidate is switched
// between a^b, a|b and ~(a^b); a second instance covers the SETTLE=0 build.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start0;
    logic [1:0] mode;

    logic [1:0] vec_out, vec_out0;
    logic       dut_out, gold_out, dut_out0, gold_out0;
    logic       busy, done, pass, busy0, done0, pass0;
    logic [2:0] err_cnt, err_cnt0;
    logic [2:0] bit_err_cnt, bit_err_cnt0;
    logic       first_fail_vld, first_fail_vld0;
    logic [1:0] first_fail_vec, first_fail_vec0;

    int nvectors = 0;
    int nmiss    = 0;
    int hamming  = 0;
    int edges;

    always #5 clk = ~clk;

    // Candidate netlist selected by mode; gold is always a^b.
    function automatic logic cand(input logic [1:0] v, input logic [1:0] m);
        case (m)
            2'd1:    return v[1] | v[0];
            2'd2:    return ~(v[1] ^ v[0]);
            default: return v[1] ^ v[0];
        endcase
    endfunction

    assign gold_out  = vec_out[1] ^ vec_out[0];
    assign dut_out   = cand(vec_out, mode);
    assign gold_out0 = vec_out0[1] ^ vec_out0[0];
    assign dut_out0  = cand(vec_out0, mode);

    truth_table_sweeper #(.N_IN(2), .N_OUT(1), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec_out),
        .dut_out(dut_out), .gold_out(gold_out), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .bit_err_cnt(bit_err_cnt),
        .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec)
    );

    truth_table_sweeper #(.N_IN(2), .N_OUT(1), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .vec_out(vec_out0),
        .dut_out(dut_out0), .gold_out(gold_out0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err_cnt0), .bit_err_cnt(bit_err_cnt0),
        .first_fail_vld(first_fail_vld0), .first_fail_vec(first_fail_vec0)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        nvectors++;
        if (actual != expected) begin
            nmiss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Pulse start on instance sel (0: SETTLE=1, 1: SETTLE=0) and count edges
    // until done; an optional extra start pulse is injected restart_at edges in.
    task automatic applyStimulus(input logic [1:0] m, input int sel, input int restart_at,
                                 output int n);
        mode = m;
        @(negedge clk);
        if (sel == 0) start = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start0 = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (sel == 0) start = (i == restart_at);
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if ((sel == 0) ? done : done0) break;
        end
    endtask

    initial begin
`ifdef SWEEP_HAMMING_EN
        hamming = 1;
`endif
        rst = 1'b1; start = 1'b0; start0 = 1'b0; mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset vec_out", vec_out, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset pass", pass, 0);
        checkOutput("reset err_cnt", err_cnt, 0);
        checkOutput("reset ffv", first_fail_vld, 0);
        checkOutput("reset done0", done0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle hold", busy, 0);

        // Matching candidate: clean sweep, done 8 edges after start
        applyStimulus(2'd0, 0, -1, edges);
        checkOutput("xor edges", edges, 8);
        checkOutput("xor err_cnt", err_cnt, 0);
        checkOutput("xor pass", pass, 1);
        checkOutput("xor ffv", first_fail_vld, 0);
        checkOutput("xor busy", busy, 0);
        checkOutput("xor vec_out", vec_out, 3);
        checkOutput("xor bit_err", bit_err_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done hold", done, 1);

        // a|b differs only at vector 3
        applyStimulus(2'd1, 0, -1, edges);
        checkOutput("or edges", edges, 8);
        checkOutput("or err_cnt", err_cnt, 1);
        checkOutput("or ffv", first_fail_vld, 1);
        checkOutput("or ffvec", first_fail_vec, 3);
        checkOutput("or pass", pass, 0);
        checkOutput("or bit_err", bit_err_cnt, hamming ? 1 : 0);

        // xnor differs everywhere; start from DONE clears counters
        applyStimulus(2'd2, 0, -1, edges);
        checkOutput("xnor edges", edges, 8);
        checkOutput("xnor err_cnt", err_cnt, 4);
        checkOutput("xnor ffvec", first_fail_vec, 0);
        checkOutput("xnor pass", pass, 0);
        checkOutput("xnor bit_err", bit_err_cnt, hamming ? 4 : 0);

        // Restart from DONE: results cleared on the accepting edge
        mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("restart err_cnt", err_cnt, 0);
        checkOutput("restart busy", busy, 1);
        checkOutput("restart done", done, 0);
        checkOutput("restart vec_out", vec_out, 0);
        checkOutput("restart ffv", first_fail_vld, 0);

        // Async reset mid-sweep, 3 cycles into RUN
        mode = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre-reset busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort vec_out", vec_out, 0);
        checkOutput("abort err_cnt", err_cnt, 0);
        checkOutput("abort ffv", first_fail_vld, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'd0, 0, -1, edges);
        checkOutput("post-reset edges", edges, 8);
        checkOutput("post-reset pass", pass, 1);
        checkOutput("post-reset err", err_cnt, 0);

        // start during RUN is ignored
        applyStimulus(2'd2, 0, 3, edges);
        checkOutput("midstart edges", edges, 8);
        checkOutput("midstart err_cnt", err_cnt, 4);
        checkOutput("midstart ffvec", first_fail_vec, 0);

        // SETTLE=0: one vector per cycle
        applyStimulus(2'd1, 1, -1, edges);
        checkOutput("s0 edges", edges, 4);
        checkOutput("s0 err_cnt", err_cnt0, 1);
        checkOutput("s0 ffvec", first_fail_vec0, 3);
        checkOutput("s0 pass", pass0, 0);
        checkOutput("s0 bit_err", bit_err_cnt0, hamming ? 1 : 0);
        applyStimulus(2'd0, 1, -1, edges);
        checkOutput("s0 clean edges", edges, 4);
        checkOutput("s0 clean pass", pass0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvectors, nmiss);
        $finish;
    end

endmodule
